fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Decoupling FIFO between fetch and if_to_id/decode. Absorbs 4-wide fetch bundles and lets
//  decode drain 0..4 entries per cycle, so a decode/issue-queue stall need not freeze the PC.
//  Flushed on redirect from execute (same flash as if_id). Entry type is DECODE_REQUIRE.
// PARAMETERS
//  DEPTH    16  entries; power of two, >= 8
//  LANES    4   push/pop width per cycle; fixed at 4 in this revision
// PORTS
//  clk          in   1                      clock, single domain
//  rst_n        in   1                      asynchronous active-low reset
//  flash        in   1                      discard all contents (branch redirect)
//  in_data      in   LANES*$bits(DECODE_REQUIRE)  fetch bundle, valid lanes contiguous from lane 0
//  in_number    in   3                      valid lanes in in_data, 0..4
//  in_ready     out  1                      queue can take a full 4-lane bundle this cycle
//  out_data     out  LANES*$bits(DECODE_REQUIRE)  oldest entries, lane 0 = oldest
//  out_number   out  3                      valid lanes on out_data, min(count,4)
//  pop_number   in   3                      lanes consumed by decode this cycle, 0..out_number
//  size_left    out  5                      DEPTH - count, registered-state derived
// BEHAVIOUR
//  - State: head, tail (log2 DEPTH bits, wrap modulo DEPTH), count (log2 DEPTH + 1 bits).
//  - Reset (async, rst_n=0): head=tail=count=0; in_ready=1, out_number=0, out_data=0,
//    size_left=DEPTH. Reset mid-operation drops all entries immediately.
//  - in_ready = (DEPTH - count >= 4), from registered count only; never depends on pop_number.
//  - Push: when in_ready && in_number>0, lanes 0..in_number-1 written at tail..tail+n-1;
//    tail += in_number. in_number>0 with in_ready=0: nothing accepted; fetch holds the bundle.
//  - Pop: head += pop_number; pop_number > out_number is clamped to out_number (assertion fires).
//  - Simultaneous push+pop: count_next = count + push_n - pop_n; both take effect the same edge.
//  - out_data is a combinational read of head..head+3 (mod DEPTH); lanes >= out_number = 0.
//  - Latency: an entry pushed at edge N is visible on out_data in cycle N+1 (no bypass).
//  - Full (count=DEPTH): in_ready=0, pops proceed. Empty: out_number=0, pop ignored.
//  - Wrap: pointer overflow wraps silently; a bundle may straddle DEPTH-1 -> 0.
//  - flash: next state head=tail=count=0; overrides push and pop in the same cycle.
// CONFIGURATION
//  FETCH_QUEUE_BYPASS_EN defined: when count==0 and flash=0, out_data/out_number mirror
//   in_data/in_number combinationally (0-cycle latency); only lanes pop_number..in_number-1
//   are written to storage; tail/count advance by in_number - pop_number.
//  Undefined: strict 1-cycle latency as above; no combinational in->out path.
// STRUCTURE
//  - defines.svh package: FQ_DEPTH constant, FQ_PTR (log2 DEPTH) and FQ_COUNT typedefs;
//    DECODE_REQUIRE already lives there.
//  - One sub-module fetch_queue_ram: DEPTH x DECODE_REQUIRE, 4 write ports at tail+i,
//    4 async read ports at head+i; no reset on storage. Pointer/count logic stays in fetch_queue.
// TESTING
//  1 Reset: assert rst_n=0 mid-stream -> out_number=0, size_left=16, in_ready=1 same cycle.
//  2 Fill: push 4/cycle, pop 0 for 4 cycles -> size_left 12,8,4,0; in_ready drops at count=16;
//    5th bundle not accepted, contents unchanged.
//  3 Wrap: pop 3/cycle while pushing 4 until tail crosses 15->0 -> out_data order matches
//    push order exactly across the boundary.
//  4 Simultaneous: count=6, push 4, pop 2 -> count=8, out_number=4, lane0 = third oldest.
//  5 Flash with push 4 and pop 2 same cycle -> next cycle count=0, out_number=0, nothing written.
//  6 Bypass (FETCH_QUEUE_BYPASS_EN): empty queue, push 3, pop 1 -> out_number=3 same cycle,
//    next cycle count=2 holding lanes 1,2; without macro out_number=0 then 3.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg
// Shared types and constants for the fetch queue slice.
//   DECODE_REQUIRE : one fetched instruction as handed to decode
//   FQ_DEPTH       : queue depth in entries (power of two, >= 8)
//   FQ_LANES       : push/pop width per cycle (fixed at 4)
//   FQ_PTR         : head/tail pointer type, wraps modulo FQ_DEPTH
//   FQ_COUNT       : occupancy type, one bit wider than FQ_PTR so "full" is representable
//   FQ_NUM         : lane-count type used on the 3-bit number ports
package fetch_queue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } DECODE_REQUIRE;

  localparam int FQ_DEPTH = 16;
  localparam int FQ_LANES = 4;
  localparam int FQ_PTR_W = $clog2(FQ_DEPTH);
  localparam int FQ_CNT_W = FQ_PTR_W + 1;
  localparam int FQ_REQ_W = $bits(DECODE_REQUIRE);

  typedef logic [FQ_PTR_W-1:0] FQ_PTR;
  typedef logic [FQ_CNT_W-1:0] FQ_COUNT;
  typedef logic [2:0]          FQ_NUM;

  function automatic FQ_NUM fq_min(input FQ_NUM a, input FQ_NUM b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// fetch_queue_ram
// FQ_DEPTH x DECODE_REQUIRE storage for the fetch queue. Storage is not reset;
// validity is tracked entirely by the pointer/count logic in fetch_queue.
//   clk     : clock
//   wr_ptr  : base write address, lane i lands at wr_ptr+i (mod depth)
//   wr_en   : per-lane write enable
//   wr_data : per-lane write data
//   rd_ptr  : base read address, lane i reads rd_ptr+i (mod depth)
//   rd_data : per-lane asynchronous read data
module fetch_queue_ram
  import fetch_queue_pkg::*;
(
  input  logic                clk,
  input  FQ_PTR               wr_ptr,
  input  logic [FQ_LANES-1:0] wr_en,
  input  DECODE_REQUIRE       wr_data [FQ_LANES],
  input  FQ_PTR               rd_ptr,
  output DECODE_REQUIRE       rd_data [FQ_LANES]
);

  DECODE_REQUIRE mem [FQ_DEPTH];

  // Pointer arithmetic wraps naturally in FQ_PTR width, so a bundle may
  // straddle the last entry and continue at entry 0.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FQ_LANES; i++) begin
      if (wr_en[i]) mem[wr_ptr + FQ_PTR'(i)] <= wr_data[i];
    end
  end

  always_comb begin
    for (int i = 0; i < FQ_LANES; i++) begin
      rd_data[i] = mem[rd_ptr + FQ_PTR'(i)];
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
// Decoupling FIFO between fetch and decode. Takes 4-wide fetch bundles and
// lets decode drain 0..4 entries per cycle; flushed by flash on a redirect.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (empty-queue 0-cycle bypass).
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   flash      : discard all contents, overrides push and pop
//   in_data    : fetch bundle, valid lanes contiguous from lane 0
//   in_number  : valid lanes in in_data (0..4)
//   in_ready   : room for a full 4-lane bundle (from registered count only)
//   out_data   : oldest entries, lane 0 oldest, invalid lanes zero
//   out_number : valid lanes on out_data
//   pop_number : lanes consumed by decode this cycle
//   size_left  : free entries
module fetch_queue
  import fetch_queue_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flash,
  input  logic [FQ_LANES*FQ_REQ_W-1:0] in_data,
  input  logic [2:0]                   in_number,
  output logic                         in_ready,
  output logic [FQ_LANES*FQ_REQ_W-1:0] out_data,
  output logic [2:0]                   out_number,
  input  logic [2:0]                   pop_number,
  output logic [FQ_CNT_W-1:0]          size_left
);

  FQ_PTR         head_q, tail_q;
  FQ_COUNT       count_q;
  DECODE_REQUIRE in_lane  [FQ_LANES];
  DECODE_REQUIRE rd_lane  [FQ_LANES];
  DECODE_REQUIRE src_lane [FQ_LANES];
  DECODE_REQUIRE wr_lane  [FQ_LANES];
  logic [FQ_LANES-1:0] wr_en;
  logic  bypass;
  FQ_NUM in_n, avail_n, out_n, pop_n, push_n, skip_n, stored_n, head_step;

  assign size_left  = FQ_COUNT'(FQ_DEPTH) - count_q;
  assign in_ready   = (size_left >= FQ_COUNT'(FQ_LANES));
  assign out_number = out_n;
  assign in_n       = (in_number > FQ_NUM'(FQ_LANES)) ? FQ_NUM'(FQ_LANES) : in_number;

  always_comb begin
    for (int i = 0; i < FQ_LANES; i++) begin
      in_lane[i] = in_data[i*FQ_REQ_W +: FQ_REQ_W];
    end
  end

  // Read side: normally the stored head window; with the bypass build an empty
  // queue mirrors the incoming bundle instead.
  always_comb begin
    avail_n = (count_q >= FQ_COUNT'(FQ_LANES)) ? FQ_NUM'(FQ_LANES) : FQ_NUM'(count_q);
    bypass  = 1'b0;
    out_n   = avail_n;
    for (int i = 0; i < FQ_LANES; i++) src_lane[i] = rd_lane[i];
`ifdef FETCH_QUEUE_BYPASS_EN
    if ((count_q == '0) && !flash) begin
      bypass = 1'b1;
      out_n  = in_n;
      for (int i = 0; i < FQ_LANES; i++) src_lane[i] = in_lane[i];
    end
`endif
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < FQ_LANES; i++) begin
      if (FQ_NUM'(i) < out_n) out_data[i*FQ_REQ_W +: FQ_REQ_W] = src_lane[i];
    end
  end

  // Write side. Over-large pops are clamped to what is visible. When bypassing,
  // lanes decode already consumed are skipped so only the remainder is stored,
  // and head stays put because those lanes never entered storage.
  always_comb begin
    pop_n     = fq_min(pop_number, out_n);
    push_n    = (in_ready && !flash) ? in_n : '0;
    skip_n    = bypass ? pop_n : '0;
    stored_n  = push_n - skip_n;
    head_step = bypass ? '0 : pop_n;
    for (int i = 0; i < FQ_LANES; i++) begin
      wr_lane[i] = '0;
      if (i + int'(skip_n) < FQ_LANES) wr_lane[i] = in_lane[i + int'(skip_n)];
      wr_en[i] = (FQ_NUM'(i) < stored_n);
    end
  end

  // Pointer and occupancy state; flash empties the queue ahead of any push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flash) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + FQ_PTR'(head_step);
      tail_q  <= tail_q + FQ_PTR'(stored_n);
      count_q <= count_q + FQ_COUNT'(stored_n) - FQ_COUNT'(head_step);
    end
  end

  fetch_queue_ram u_ram (
    .clk     (clk),
    .wr_ptr  (tail_q),
    .wr_en   (wr_en),
    .wr_data (wr_lane),
    .rd_ptr  (head_q),
    .rd_data (rd_lane)
  );

  // Decode must never consume more lanes than it was shown.
  pop_in_range: assert property (@(posedge clk) disable iff (!rst_n) pop_number <= out_number);

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
// Directed bench for fetch_queue: reset, fill/full, wrap, simultaneous
// push+pop, flash and the empty-queue latency behaviour.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int W  = $bits(DECODE_REQUIRE);
  localparam int LW = FQ_LANES * W;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                flash = 1'b0;
  logic [LW-1:0]       in_data = '0;
  logic [2:0]          in_number = '0;
  logic [2:0]          pop_number = '0;
  logic                in_ready;
  logic [LW-1:0]       out_data;
  logic [2:0]          out_number;
  logic [FQ_CNT_W-1:0] size_left;

  int checks = 0;
  int errors = 0;
  int next_id = 0;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flash      (flash),
    .in_data    (in_data),
    .in_number  (in_number),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_number (out_number),
    .pop_number (pop_number),
    .size_left  (size_left)
  );

  // Each entry carries a recognisable pattern derived from its sequence id.
  function automatic logic [W-1:0] mk(input int id);
    return {32'h0000_1000 + 32'(id * 4), 32'hA000_0000 | 32'(id)};
  endfunction

  function automatic logic [W-1:0] lane(input int i);
    return out_data[i*W +: W];
  endfunction

  task automatic drive(input int push_n, input int base, input int pop_n, input logic fl);
    in_data = '0;
    for (int i = 0; i < push_n; i++) in_data[i*W +: W] = mk(base + i);
    in_number  = 3'(push_n);
    pop_number = 3'(pop_n);
    flash      = fl;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out_number !== 3'd0) begin errors++; $display("[TB] FAIL reset_out_number: got %0d expected 0", out_number); end
    checks++; if (size_left !== 5'd16) begin errors++; $display("[TB] FAIL reset_size_left: got %0d expected 16", size_left); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    rst_n = 1'b1;
    drive(4, next_id, 0, 1'b0);
    tick();
    idle();
    checks++; if (out_number !== 3'd4) begin errors++; $display("[TB] FAIL pre_reset_out_number: got %0d expected 4", out_number); end
    next_id += 4;
    rst_n = 1'b0;
    #1;
    checks++; if (out_number !== 3'd0) begin errors++; $display("[TB] FAIL midreset_out_number: got %0d expected 0", out_number); end
    checks++; if (size_left !== 5'd16) begin errors++; $display("[TB] FAIL midreset_size_left: got %0d expected 16", size_left); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL midreset_out_data: got %h expected 0", out_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    int base = next_id;
    next_id += 16;
    for (int c = 0; c < 4; c++) begin
      drive(4, base + 4*c, 0, 1'b0);
      if (c == 0) begin
        checks++; if (out_number !== (BYPASS ? 3'd4 : 3'd0)) begin errors++; $display("[TB] FAIL fill_latency: got %0d expected %0d", out_number, BYPASS ? 4 : 0); end
      end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL fill_in_ready c=%0d: got %b expected 1", c, in_ready); end
      tick();
      checks++; if (size_left !== 5'(12 - 4*c)) begin errors++; $display("[TB] FAIL fill_size_left c=%0d: got %0d expected %0d", c, size_left, 12 - 4*c); end
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_in_ready: got %b expected 0", in_ready); end
    drive(4, 900, 0, 1'b0);
    tick();
    idle();
    checks++; if (size_left !== 5'd0) begin errors++; $display("[TB] FAIL full_reject_size_left: got %0d expected 0", size_left); end
    checks++; if (lane(0) !== mk(base)) begin errors++; $display("[TB] FAIL full_lane0: got %h expected %h", lane(0), mk(base)); end
    checks++; if (lane(3) !== mk(base + 3)) begin errors++; $display("[TB] FAIL full_lane3: got %h expected %h", lane(3), mk(base + 3)); end
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 4, 1'b0);
      checks++; if (out_number !== 3'd4) begin errors++; $display("[TB] FAIL drain_out_number c=%0d: got %0d expected 4", c, out_number); end
      for (int i = 0; i < 4; i++) begin
        checks++; if (lane(i) !== mk(base + 4*c + i)) begin errors++; $display("[TB] FAIL drain_lane c=%0d i=%0d: got %h expected %h", c, i, lane(i), mk(base + 4*c + i)); end
      end
      tick();
    end
    idle();
    checks++; if (size_left !== 5'd16) begin errors++; $display("[TB] FAIL drain_size_left: got %0d expected 16", size_left); end
    checks++; if (out_number !== 3'd0) begin errors++; $display("[TB] FAIL drain_out_number_empty: got %0d expected 0", out_number); end
  endtask

  task automatic test_wrap();
    int base = next_id;
    int head_id = base;
    int push_id = base;
    int cnt = 0;
    int exp_n;
    int p;
    next_id += 27;
    // A 3-entry lead-in offsets tail so a later 4-lane bundle straddles 15 -> 0.
    drive(3, push_id, 0, 1'b0);
    tick();
    push_id += 3;
    cnt = 3;
    for (int k = 1; k <= 6; k++) begin
      drive(4, push_id, 3, 1'b0);
      exp_n = (cnt > 4) ? 4 : cnt;
      checks++; if (out_number !== 3'(exp_n)) begin errors++; $display("[TB] FAIL wrap_out_number k=%0d: got %0d expected %0d", k, out_number, exp_n); end
      for (int i = 0; i < exp_n; i++) begin
        checks++; if (lane(i) !== mk(head_id + i)) begin errors++; $display("[TB] FAIL wrap_lane k=%0d i=%0d: got %h expected %h", k, i, lane(i), mk(head_id + i)); end
      end
      tick();
      push_id += 4;
      head_id += 3;
      cnt += 1;
    end
    for (int g = 0; g < 8 && cnt > 0; g++) begin
      p = (cnt > 4) ? 4 : cnt;
      drive(0, 0, p, 1'b0);
      for (int i = 0; i < p; i++) begin
        checks++; if (lane(i) !== mk(head_id + i)) begin errors++; $display("[TB] FAIL wrap_drain_lane i=%0d: got %h expected %h", i, lane(i), mk(head_id + i)); end
      end
      tick();
      head_id += p;
      cnt -= p;
    end
    idle();
    checks++; if (size_left !== 5'd16) begin errors++; $display("[TB] FAIL wrap_size_left: got %0d expected 16", size_left); end
  endtask

  task automatic test_simultaneous();
    int s = next_id;
    next_id += 10;
    drive(4, s, 0, 1'b0);
    tick();
    drive(2, s + 4, 0, 1'b0);
    tick();
    idle();
    checks++; if (size_left !== 5'd10) begin errors++; $display("[TB] FAIL simul_setup_size_left: got %0d expected 10", size_left); end
    drive(4, s + 6, 2, 1'b0);
    checks++; if (lane(0) !== mk(s)) begin errors++; $display("[TB] FAIL simul_pre_lane0: got %h expected %h", lane(0), mk(s)); end
    tick();
    idle();
    checks++; if (size_left !== 5'd8) begin errors++; $display("[TB] FAIL simul_size_left: got %0d expected 8", size_left); end
    checks++; if (out_number !== 3'd4) begin errors++; $display("[TB] FAIL simul_out_number: got %0d expected 4", out_number); end
    checks++; if (lane(0) !== mk(s + 2)) begin errors++; $display("[TB] FAIL simul_lane0: got %h expected %h", lane(0), mk(s + 2)); end
    drive(0, 0, 4, 1'b0);
    tick();
    idle();
    checks++; if (lane(0) !== mk(s + 6)) begin errors++; $display("[TB] FAIL simul_next_lane0: got %h expected %h", lane(0), mk(s + 6)); end
    checks++; if (lane(3) !== mk(s + 9)) begin errors++; $display("[TB] FAIL simul_next_lane3: got %h expected %h", lane(3), mk(s + 9)); end
    drive(0, 0, 4, 1'b0);
    tick();
    idle();
    checks++; if (size_left !== 5'd16) begin errors++; $display("[TB] FAIL simul_drain_size_left: got %0d expected 16", size_left); end
  endtask

  task automatic test_flash();
    int base = next_id;
    next_id += 9;
    drive(4, base, 0, 1'b0);
    tick();
    drive(4, base + 4, 2, 1'b1);
    tick();
    idle();
    checks++; if (size_left !== 5'd16) begin errors++; $display("[TB] FAIL flash_size_left: got %0d expected 16", size_left); end
    checks++; if (out_number !== 3'd0) begin errors++; $display("[TB] FAIL flash_out_number: got %0d expected 0", out_number); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flash_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL flash_out_data: got %h expected 0", out_data); end
    drive(1, base + 8, 0, 1'b0);
    tick();
    idle();
    checks++; if (out_number !== 3'd1) begin errors++; $display("[TB] FAIL post_flash_out_number: got %0d expected 1", out_number); end
    checks++; if (lane(0) !== mk(base + 8)) begin errors++; $display("[TB] FAIL post_flash_lane0: got %h expected %h", lane(0), mk(base + 8)); end
    checks++; if (lane(1) !== '0) begin errors++; $display("[TB] FAIL post_flash_lane1: got %h expected 0", lane(1)); end
    drive(0, 0, 1, 1'b0);
    tick();
    idle();
    checks++; if (size_left !== 5'd16) begin errors++; $display("[TB] FAIL post_flash_size_left: got %0d expected 16", size_left); end
  endtask

  task automatic test_bypass();
    int b = next_id;
    next_id += 3;
`ifdef FETCH_QUEUE_BYPASS_EN
    drive(3, b, 1, 1'b0);
    checks++; if (out_number !== 3'd3) begin errors++; $display("[TB] FAIL bypass_out_number: got %0d expected 3", out_number); end
    checks++; if (lane(0) !== mk(b)) begin errors++; $display("[TB] FAIL bypass_lane0: got %h expected %h", lane(0), mk(b)); end
    tick();
    idle();
    checks++; if (size_left !== 5'd14) begin errors++; $display("[TB] FAIL bypass_size_left: got %0d expected 14", size_left); end
    checks++; if (out_number !== 3'd2) begin errors++; $display("[TB] FAIL bypass_next_out_number: got %0d expected 2", out_number); end
    checks++; if (lane(0) !== mk(b + 1)) begin errors++; $display("[TB] FAIL bypass_next_lane0: got %h expected %h", lane(0), mk(b + 1)); end
    checks++; if (lane(1) !== mk(b + 2)) begin errors++; $display("[TB] FAIL bypass_next_lane1: got %h expected %h", lane(1), mk(b + 2)); end
    checks++; if (lane(2) !== '0) begin errors++; $display("[TB] FAIL bypass_next_lane2: got %h expected 0", lane(2)); end
    drive(0, 0, 2, 1'b0);
    tick();
`else
    drive(3, b, 0, 1'b0);
    checks++; if (out_number !== 3'd0) begin errors++; $display("[TB] FAIL nobypass_out_number: got %0d expected 0", out_number); end
    checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL nobypass_out_data: got %h expected 0", out_data); end
    tick();
    idle();
    checks++; if (out_number !== 3'd3) begin errors++; $display("[TB] FAIL nobypass_next_out_number: got %0d expected 3", out_number); end
    checks++; if (size_left !== 5'd13) begin errors++; $display("[TB] FAIL nobypass_size_left: got %0d expected 13", size_left); end
    checks++; if (lane(0) !== mk(b)) begin errors++; $display("[TB] FAIL nobypass_lane0: got %h expected %h", lane(0), mk(b)); end
    checks++; if (lane(2) !== mk(b + 2)) begin errors++; $display("[TB] FAIL nobypass_lane2: got %h expected %h", lane(2), mk(b + 2)); end
    checks++; if (lane(3) !== '0) begin errors++; $display("[TB] FAIL nobypass_lane3: got %h expected 0", lane(3)); end
    drive(0, 0, 3, 1'b0);
    tick();
`endif
    idle();
    checks++; if (size_left !== 5'd16) begin errors++; $display("[TB] FAIL latency_end_size_left: got %0d expected 16", size_left); end
  endtask

  initial begin
    $display("[TB] fetch_queue bench start");
    test_reset();
    test_fill();
    test_wrap();
    test_simultaneous();
    test_flash();
    test_bypass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
